// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: shared types, state encoding and opcode constants for the 6502 sequencer.
package cpu_sequencer_pkg;
  typedef logic [7:0] data_t;
  typedef logic [15:0] addr_t;
  typedef logic mw_t;
  typedef enum logic {MM_PC = 1'b0, MM_ADDR = 1'b1} mm_t;
  typedef enum logic [3:0] {FETCH, DECODE, LDI, OPLO, OPHI, RDABS, LDM, WRABS, HALT} seq_state_t;
  localparam data_t OP_NOP     = 8'hEA;
  localparam data_t OP_BRK     = 8'h00;
  localparam data_t OP_LDA_IMM = 8'hA9;
  localparam data_t OP_LDA_ABS = 8'hAD;
  localparam data_t OP_STA_ABS = 8'h8D;
  localparam data_t OP_JMP_ABS = 8'h4C;
endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: memory-side bus between the sequencer and cpumemory/memmux/datapath.
interface cpu_sequencer_if;
  import cpu_sequencer_pkg::*;
  data_t mem_rdata;
  addr_t pc;
  addr_t aaddr;
  mm_t mm;
  mw_t mw;
  logic il;
  logic a_load;
  modport master (input mem_rdata, output pc, aaddr, mm, mw, il, a_load);
  modport slave (output mem_rdata, input pc, aaddr, mm, mw, il, a_load);
endinterface

// File: rtl/cpu_sequencer_opdecode.sv
// cpu_sequencer_opdecode: classifies an opcode into the instruction groups the FSM branches on.
module cpu_sequencer_opdecode
  import cpu_sequencer_pkg::*;
(
  input  data_t opcode,
  output logic  needs_operand,
  output logic  is_abs,
  output logic  is_jmp,
  output logic  is_store,
  output logic  is_halt,
  output logic  is_illegal
);
  assign is_jmp = opcode == OP_JMP_ABS;
  assign is_store = opcode == OP_STA_ABS;
  assign is_halt = opcode == OP_BRK;
  assign is_abs = is_jmp || is_store || opcode == OP_LDA_ABS;
  assign needs_operand = is_abs || opcode == OP_LDA_IMM;
  assign is_illegal = !(needs_operand || is_halt || opcode == OP_NOP);
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: Moore FSM running fetch/decode/operand/execute for the 6502 subset.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter addr_t RESET_PC = 16'h0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  cpu_sequencer_if.master         bus,
  output logic                    halted,
  output logic                    illegal,
  output seq_state_t              state
);
  seq_state_t state_q, state_d;
  addr_t pc_q, pc_d, aaddr_q, aaddr_d;
  data_t ir_q, ir_d, lo_q, lo_d;
  logic illegal_q, illegal_d;
  mm_t mm_q, mm_d;
  mw_t mw_q, mw_d;
  logic il_q, il_d, a_load_q, a_load_d, halted_q, halted_d;
  logic needs_operand, is_abs, is_jmp, is_store, is_halt, is_illegal;
  // In DECODE the opcode is still on the bus; afterwards the latched copy is used.
  cpu_sequencer_opdecode u_dec (
    .opcode       (state_q == DECODE ? bus.mem_rdata : ir_q),
    .needs_operand(needs_operand),
    .is_abs       (is_abs),
    .is_jmp       (is_jmp),
    .is_store     (is_store),
    .is_halt      (is_halt),
    .is_illegal   (is_illegal)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    aaddr_d = aaddr_q;
    ir_d = ir_q;
    lo_d = lo_q;
    illegal_d = illegal_q;
    case (state_q)
      FETCH: if (run) begin
        pc_d = pc_q + 16'd1;
        state_d = DECODE;
      end
      DECODE: begin
        ir_d = bus.mem_rdata;
        if (is_halt || is_illegal) begin
          illegal_d = illegal_q | is_illegal;
          state_d = HALT;
        end else if (needs_operand) begin
          pc_d = pc_q + 16'd1;
          state_d = is_abs ? OPLO : LDI;
        end else state_d = FETCH;
      end
      OPLO: begin
        lo_d = bus.mem_rdata;
        pc_d = pc_q + 16'd1;
        state_d = OPHI;
      end
      OPHI: begin
        if (is_jmp) pc_d = {bus.mem_rdata, lo_q};
        else aaddr_d = {bus.mem_rdata, lo_q};
        state_d = is_jmp ? FETCH : is_store ? WRABS : RDABS;
      end
      RDABS: state_d = LDM;
      LDI, LDM, WRABS: state_d = FETCH;
      default: state_d = HALT;
    endcase
    mm_d = (state_d == RDABS || state_d == WRABS) ? MM_ADDR : MM_PC;
    mw_d = state_d == WRABS;
    il_d = state_d == DECODE;
    a_load_d = state_d == LDI || state_d == LDM;
    halted_d = state_d == HALT;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      aaddr_q <= '0;
      ir_q <= '0;
      lo_q <= '0;
      illegal_q <= 1'b0;
      mm_q <= MM_PC;
      mw_q <= 1'b0;
      il_q <= 1'b0;
      a_load_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      aaddr_q <= aaddr_d;
      ir_q <= ir_d;
      lo_q <= lo_d;
      illegal_q <= illegal_d;
      mm_q <= mm_d;
      mw_q <= mw_d;
      il_q <= il_d;
      a_load_q <= a_load_d;
      halted_q <= halted_d;
    end
  end
  assign bus.pc = pc_q;
  assign bus.aaddr = aaddr_q;
  assign bus.mm = mm_q;
  assign bus.mw = mw_q;
  assign bus.il = il_q;
  assign bus.a_load = a_load_q;
  assign halted = halted_q;
  assign illegal = illegal_q;
  assign state = state_q;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed checks of the sequencer against a synchronous-read memory model.
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  logic halted0, illegal0, halted1, illegal1;
  seq_state_t state0, state1;
  logic [7:0] mem0 [0:65535];
  logic [7:0] mem1 [0:65535];
  int tests = 0;
  int failed = 0;
  cpu_sequencer_if b0 ();
  cpu_sequencer_if b1 ();
  cpu_sequencer #(.RESET_PC(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .run(run), .bus(b0.master),
    .halted(halted0), .illegal(illegal0), .state(state0)
  );
  cpu_sequencer #(.RESET_PC(16'hFFFE)) dut1 (
    .clk(clk), .reset(reset), .run(run), .bus(b1.master),
    .halted(halted1), .illegal(illegal1), .state(state1)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    b0.mem_rdata <= mem0[b0.mm == MM_ADDR ? b0.aaddr : b0.pc];
    b1.mem_rdata <= mem1[b1.mm == MM_ADDR ? b1.aaddr : b1.pc];
    if (b0.mw) mem0[b0.aaddr] <= 8'hA5;
  end
  task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) begin
      mem0[i] = OP_NOP;
      mem1[i] = OP_NOP;
    end
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    clear_mem();
    mem0[0] = OP_NOP; mem0[1] = OP_NOP; mem0[2] = OP_BRK;
    run = 1'b1;
    @(negedge clk);
    ck("rst state", 32'(state0), 32'(FETCH));
    ck("rst pc", 32'(b0.pc), 32'h0);
    ck("rst aaddr", 32'(b0.aaddr), 32'h0);
    ck("rst mw", 32'(b0.mw), 32'h0);
    ck("rst il", 32'(b0.il), 32'h0);
    ck("rst halted", 32'(halted0), 32'h0);
    ck("rst pc1", 32'(b1.pc), 32'hFFFE);
    @(negedge clk) reset = 1'b1;
    ck("nop c1 state", 32'(state0), 32'(FETCH));
    step(1);
    ck("nop c2 state", 32'(state0), 32'(DECODE));
    ck("nop c2 pc", 32'(b0.pc), 32'h1);
    ck("nop c2 il", 32'(b0.il), 32'h1);
    step(1);
    ck("nop c3 state", 32'(state0), 32'(FETCH));
    ck("nop c3 il", 32'(b0.il), 32'h0);
    step(1);
    ck("nop c4 pc", 32'(b0.pc), 32'h2);
    ck("nop c4 il", 32'(b0.il), 32'h1);
    step(3);
    ck("brk state", 32'(state0), 32'(HALT));
    ck("brk pc", 32'(b0.pc), 32'h3);
    ck("brk halted", 32'(halted0), 32'h1);
    ck("brk illegal", 32'(illegal0), 32'h0);
    clear_mem();
    mem0[0] = OP_LDA_IMM; mem0[1] = 8'h5A;
    do_reset();
    step(2);
    ck("ldi c3 state", 32'(state0), 32'(LDI));
    ck("ldi c3 a_load", 32'(b0.a_load), 32'h1);
    ck("ldi c3 rdata", 32'(b0.mem_rdata), 32'h5A);
    run = 1'b0;
    step(1);
    ck("ldi c4 state", 32'(state0), 32'(FETCH));
    ck("ldi c4 a_load", 32'(b0.a_load), 32'h0);
    ck("ldi c4 pc", 32'(b0.pc), 32'h2);
    step(10);
    ck("run0 state", 32'(state0), 32'(FETCH));
    ck("run0 pc", 32'(b0.pc), 32'h2);
    clear_mem();
    mem0[0] = OP_LDA_ABS; mem0[1] = 8'h34; mem0[2] = 8'h12;
    mem0[3] = OP_STA_ABS; mem0[4] = 8'h00; mem0[5] = 8'h20;
    mem0[16'h1234] = 8'h77;
    run = 1'b1;
    do_reset();
    step(3);
    ck("lda c4 state", 32'(state0), 32'(OPHI));
    ck("lda c4 pc", 32'(b0.pc), 32'h3);
    step(1);
    ck("lda c5 mm", 32'(b0.mm), 32'(MM_ADDR));
    ck("lda c5 aaddr", 32'(b0.aaddr), 32'h1234);
    ck("lda c5 a_load", 32'(b0.a_load), 32'h0);
    step(1);
    ck("lda c6 a_load", 32'(b0.a_load), 32'h1);
    ck("lda c6 rdata", 32'(b0.mem_rdata), 32'h77);
    ck("lda c6 mm", 32'(b0.mm), 32'(MM_PC));
    step(1);
    ck("lda c7 state", 32'(state0), 32'(FETCH));
    step(3);
    ck("sta c4 mw", 32'(b0.mw), 32'h0);
    step(1);
    ck("sta c5 state", 32'(state0), 32'(WRABS));
    ck("sta c5 aaddr", 32'(b0.aaddr), 32'h2000);
    ck("sta c5 mw", 32'(b0.mw), 32'h1);
    ck("sta c5 mm", 32'(b0.mm), 32'(MM_ADDR));
    run = 1'b0;
    step(1);
    ck("sta c6 mw", 32'(b0.mw), 32'h0);
    ck("sta c6 state", 32'(state0), 32'(FETCH));
    ck("sta c6 pc", 32'(b0.pc), 32'h6);
    ck("sta mem", 32'(mem0[16'h2000]), 32'hA5);
    clear_mem();
    mem1[16'hFFFE] = OP_JMP_ABS; mem1[16'hFFFF] = 8'h10; mem1[0] = 8'h80;
    run = 1'b1;
    do_reset();
    ck("jmp c1 pc", 32'(b1.pc), 32'hFFFE);
    step(1);
    ck("jmp c2 pc", 32'(b1.pc), 32'hFFFF);
    step(1);
    ck("jmp c3 wrap", 32'(b1.pc), 32'h0000);
    step(2);
    ck("jmp c5 state", 32'(state1), 32'(FETCH));
    ck("jmp c5 pc", 32'(b1.pc), 32'h8010);
    ck("jmp c5 aaddr", 32'(b1.aaddr), 32'h0000);
    clear_mem();
    mem0[0] = 8'hFF;
    do_reset();
    step(2);
    ck("ill state", 32'(state0), 32'(HALT));
    ck("ill halted", 32'(halted0), 32'h1);
    ck("ill illegal", 32'(illegal0), 32'h1);
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      step(1);
    end
    ck("ill stays", 32'(state0), 32'(HALT));
    ck("ill sticky", 32'(illegal0), 32'h1);
    mem0[0] = OP_STA_ABS; mem0[1] = 8'h00; mem0[2] = 8'h20;
    run = 1'b1;
    do_reset();
    ck("rst clr illegal", 32'(illegal0), 32'h0);
    step(4);
    ck("abort pre mw", 32'(b0.mw), 32'h1);
    #1 reset = 1'b0;
    #1;
    ck("abort mw", 32'(b0.mw), 32'h0);
    ck("abort state", 32'(state0), 32'(FETCH));
    ck("abort pc", 32'(b0.pc), 32'h0);
    @(negedge clk) reset = 1'b1;
    step(1);
    ck("post rst state", 32'(state0), 32'(DECODE));
    ck("post rst pc", 32'(b0.pc), 32'h1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
